// File: rtl/branch_resolve_unit.sv
// In-order branch resolve queue: holds fetch predictions and emits predictor updates on resolve.
// Optional statistics counters are enabled by defining BRU_STATS_EN.
module branch_resolve_unit #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             pred_valid,
    input  logic [31:0]      pred_addr,
    input  logic             pred_taken,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic             flush,
    output logic             Branch_resolved,
    output logic [31:0]      Branch_addr_OUT,
    output logic             mispredict,
    output logic [PTR_W:0]   count,
    output logic             err_overflow,
    output logic             err_underflow
`ifdef BRU_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
`endif
);

    // Handshake: a prediction transfers on a rising edge where pred_valid && pred_ready;
    // pred_ready depends only on the current occupancy, never on same-cycle pops.
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [31:0]      mem_addr  [DEPTH];
    logic             mem_taken [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic full;
    logic empty;
    logic do_pop;
    logic wrong;
    logic do_push;
    logic overflow_hit;
    logic underflow_hit;

    always_comb begin
        full          = (count == FULL_CNT);
        empty         = (count == '0);
        pred_ready    = !full;
        do_pop        = !flush && res_valid && !empty;
        wrong         = do_pop && (res_taken != mem_taken[rd_ptr]);
        // A mispredict makes anything pushed this cycle wrong-path as well.
        do_push       = !flush && pred_valid && !full && (pred_addr != 32'd0) && !wrong;
        overflow_hit  = !flush && pred_valid && full && (pred_addr != 32'd0);
        underflow_hit = !flush && res_valid && empty;
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_addr[wr_ptr]  <= pred_addr;
            mem_taken[wr_ptr] <= pred_taken;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush || wrong) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Update outputs are single-cycle: zero unless a pop happened on the last edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Branch_addr_OUT <= '0;
            Branch_resolved <= 1'b0;
            mispredict      <= 1'b0;
            err_overflow    <= 1'b0;
            err_underflow   <= 1'b0;
        end else begin
            Branch_addr_OUT <= do_pop ? mem_addr[rd_ptr] : 32'd0;
            Branch_resolved <= do_pop && res_taken;
            mispredict      <= wrong;
            if (overflow_hit)  err_overflow  <= 1'b1;
            if (underflow_hit) err_underflow <= 1'b1;
        end
    end

`ifdef BRU_STATS_EN
    localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (do_pop && (stat_branches != '1))
                stat_branches <= stat_branches + STAT_ONE;
            if (wrong && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + STAT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: queue-based reference model, per-cycle compare, directed cases.
// Define BRU_STATS_EN to also cover the statistics counters (including a 2-bit saturating copy).
module tb_branch_resolve_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_addr = '0;
    logic        pred_taken = 1'b0;
    logic        pred_ready;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic        flush = 1'b0;
    logic        Branch_resolved;
    logic [31:0] Branch_addr_OUT;
    logic        mispredict;
    logic [3:0]  count;
    logic        err_overflow;
    logic        err_underflow;
`ifdef BRU_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
    logic [1:0]  s_stat_branches;
    logic [1:0]  s_stat_mispredicts;
    logic        s_ready, s_res, s_misp, s_ovf, s_unf;
    logic [31:0] s_addr;
    logic [3:0]  s_count;
`endif

    branch_resolve_unit #(.DEPTH(8), .PTR_W(3), .CNT_W(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_taken(pred_taken),
        .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
        .Branch_resolved(Branch_resolved), .Branch_addr_OUT(Branch_addr_OUT),
        .mispredict(mispredict), .count(count),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
`ifdef BRU_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

`ifdef BRU_STATS_EN
    branch_resolve_unit #(.DEPTH(8), .PTR_W(3), .CNT_W(2)) dut_small (
        .CLK(CLK), .RESET(RESET),
        .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_taken(pred_taken),
        .pred_ready(s_ready),
        .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
        .Branch_resolved(s_res), .Branch_addr_OUT(s_addr),
        .mispredict(s_misp), .count(s_count),
        .err_overflow(s_ovf), .err_underflow(s_unf),
        .stat_branches(s_stat_branches), .stat_mispredicts(s_stat_mispredicts)
    );
`endif

    // Clock / reset
    always #5 CLK = ~CLK;

    // Reference model: program-order queue of {addr, taken}
    logic [32:0] exp_q[$];
    logic [31:0] exp_addr = '0;
    logic        exp_res = 1'b0;
    logic        exp_misp = 1'b0;
    logic        exp_ovf = 1'b0;
    logic        exp_unf = 1'b0;
    longint      exp_br = 0;
    longint      exp_mp = 0;

    int n_cmp = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            exp_q.delete();
            exp_addr = '0; exp_res = 1'b0; exp_misp = 1'b0;
            exp_ovf = 1'b0; exp_unf = 1'b0; exp_br = 0; exp_mp = 0;
        end else if (flush) begin
            exp_q.delete();
            exp_addr = '0; exp_res = 1'b0; exp_misp = 1'b0;
        end else begin
            int          sz;
            bit          wrong;
            logic [32:0] head;
            sz = exp_q.size();
            wrong = 1'b0;
            if (res_valid && sz == 0) exp_unf = 1'b1;
            if (pred_valid && pred_addr != 0 && sz == 8) exp_ovf = 1'b1;
            if (res_valid && sz > 0) begin
                head = exp_q.pop_front();
                exp_addr = head[32:1];
                exp_res = res_taken;
                wrong = (res_taken != head[0]);
                exp_misp = wrong;
                exp_br = exp_br + 1;
                if (wrong) exp_mp = exp_mp + 1;
            end else begin
                exp_addr = '0; exp_res = 1'b0; exp_misp = 1'b0;
            end
            if (wrong) exp_q.delete();
            else if (pred_valid && pred_addr != 0 && sz < 8) exp_q.push_back({pred_addr, pred_taken});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare, once per cycle away from the active edge
    always @(negedge CLK) begin
        if (check_en) begin
            chk("count", {28'd0, count}, exp_q.size());
            chk("pred_ready", {31'd0, pred_ready}, {31'd0, exp_q.size() != 8});
            chk("Branch_addr_OUT", Branch_addr_OUT, exp_addr);
            chk("Branch_resolved", {31'd0, Branch_resolved}, {31'd0, exp_res});
            chk("mispredict", {31'd0, mispredict}, {31'd0, exp_misp});
            chk("err_overflow", {31'd0, err_overflow}, {31'd0, exp_ovf});
            chk("err_underflow", {31'd0, err_underflow}, {31'd0, exp_unf});
`ifdef BRU_STATS_EN
            chk("stat_branches", stat_branches, 32'(exp_br > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : exp_br));
            chk("stat_mispredicts", stat_mispredicts, 32'(exp_mp > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : exp_mp));
            chk("small_stat_branches", {30'd0, s_stat_branches}, 32'(exp_br > 3 ? 3 : exp_br));
            chk("small_stat_mispredicts", {30'd0, s_stat_mispredicts}, 32'(exp_mp > 3 ? 3 : exp_mp));
`endif
        end
    end

    // Driver tasks: inputs change 1 time unit after a rising edge
    task automatic cyc(input logic pv, input logic [31:0] pa, input logic pt,
                       input logic rv, input logic rt, input logic fl);
        pred_valid = pv; pred_addr = pa; pred_taken = pt;
        res_valid = rv; res_taken = rt; flush = fl;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        // Reset out of time zero
        #2;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        check_en = 1'b1;
        chk("reset_count", {28'd0, count}, 32'd0);
        chk("reset_ready", {31'd0, pred_ready}, 32'd1);

        // Reset mid-queue takes effect asynchronously
        cyc(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t1_addr_before", Branch_addr_OUT, 32'h100);
        chk("t1_count_before", {28'd0, count}, 32'd2);
        RESET = 1'b0;
        #2;
        chk("t1_count", {28'd0, count}, 32'd0);
        chk("t1_addr", Branch_addr_OUT, 32'd0);
        chk("t1_ready", {31'd0, pred_ready}, 32'd1);
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        // In-order correct resolves
        cyc(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h404, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_count2", {28'd0, count}, 32'd2);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t2_addr0", Branch_addr_OUT, 32'h400);
        chk("t2_res0", {31'd0, Branch_resolved}, 32'd1);
        chk("t2_misp0", {31'd0, mispredict}, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_addr1", Branch_addr_OUT, 32'h404);
        chk("t2_res1", {31'd0, Branch_resolved}, 32'd0);
        chk("t2_count0", {28'd0, count}, 32'd0);
        idle();
        chk("t2_addr_idle", Branch_addr_OUT, 32'd0);

        // Mispredict flushes younger entries and the same-cycle push
        cyc(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h408, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h40C, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h500, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_addr", Branch_addr_OUT, 32'h400);
        chk("t3_res", {31'd0, Branch_resolved}, 32'd0);
        chk("t3_misp", {31'd0, mispredict}, 32'd1);
        chk("t3_count", {28'd0, count}, 32'd0);
        idle();
        chk("t3_misp_pulse", {31'd0, mispredict}, 32'd0);
        chk("t3_count_after", {28'd0, count}, 32'd0);

        // Fill, overflow, pop+push with pointer wrap
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h1000 + 32'(4 * i), 1'(i), 1'b0, 1'b0, 1'b0);
        chk("t4_full_ready", {31'd0, pred_ready}, 32'd0);
        chk("t4_full_count", {28'd0, count}, 32'd8);
        cyc(1'b1, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_ovf", {31'd0, err_overflow}, 32'd1);
        chk("t4_ovf_count", {28'd0, count}, 32'd8);
        cyc(1'b1, 32'h2004, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_pop_full_addr", Branch_addr_OUT, 32'h1000);
        chk("t4_pop_full_count", {28'd0, count}, 32'd7);
        cyc(1'b1, 32'h2008, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_refill_count", {28'd0, count}, 32'd8);
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 8) cyc(1'b0, 32'd0, 1'b0, 1'b1, exp_q[0][0], 1'b0);
            else cyc(1'b1, 32'h3000 + 32'(4 * k), 1'(k), 1'b1, exp_q[0][0], 1'b0);
        end
        chk("t4_steady_count", {28'd0, count}, 32'd7);

        // Underflow and flush
        do_reset();
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t5_unf", {31'd0, err_underflow}, 32'd1);
        chk("t5_unf_addr", Branch_addr_OUT, 32'd0);
        chk("t5_no_ovf", {31'd0, err_overflow}, 32'd0);
        cyc(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h604, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h608, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t5_flush_count", {28'd0, count}, 32'd0);
        chk("t5_flush_addr", Branch_addr_OUT, 32'd0);
        cyc(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_zero_addr_drop", {28'd0, count}, 32'd0);

`ifdef BRU_STATS_EN
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h700 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 32'd0, 1'b0, 1'b1, (i < 3) ? 1'b0 : 1'b1, 1'b0);
        end
        idle();
        chk("t6_branches", stat_branches, 32'd10);
        chk("t6_mispredicts", stat_mispredicts, 32'd3);
        chk("t6_small_branches_sat", {30'd0, s_stat_branches}, 32'd3);
        chk("t6_small_mispredicts", {30'd0, s_stat_mispredicts}, 32'd3);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            logic        pv, pt, rv, rt, fl;
            logic [31:0] pa;
            pv = ($urandom_range(0, 99) < 60);
            pa = ($urandom_range(0, 99) < 5) ? 32'd0 : {16'd0, 14'($urandom_range(1, 16383)), 2'b00};
            pt = 1'($urandom);
            rv = ($urandom_range(0, 99) < 45);
            if (exp_q.size() > 0 && $urandom_range(0, 99) < 85) rt = exp_q[0][0];
            else rt = 1'($urandom);
            fl = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 999) < 3) do_reset();
            else cyc(pv, pa, pt, rv, rt, fl);
        end
        idle();

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
